// File: rtl/tlb_unit.sv
// tlb_unit: fully associative TLB with two independent search ports, indexed or
// fill writes, a registered read port and a one-entry-per-cycle invalidate walker.
module tlb_unit #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s0_req,
    input  logic [18:0]         s0_vppn,
    input  logic                s0_va_bit12,
    input  logic [9:0]          s0_asid,
    output logic                s0_rsp_valid,
    output logic [32+IDXW:0]    s0_rsp,
    input  logic                s1_req,
    input  logic [18:0]         s1_vppn,
    input  logic                s1_va_bit12,
    input  logic [9:0]          s1_asid,
    output logic                s1_rsp_valid,
    output logic [32+IDXW:0]    s1_rsp,
    input  logic                we,
    input  logic                w_fill,
    input  logic [IDXW-1:0]     w_index,
    input  logic [88:0]         w_entry,
    output logic                w_ready,
    output logic [IDXW-1:0]     w_fill_index,
    input  logic                r_req,
    input  logic [IDXW-1:0]     r_index,
    output logic                r_valid,
    output logic [88:0]         r_entry,
    input  logic                inv_start,
    input  logic [4:0]          inv_op,
    input  logic [9:0]          inv_asid,
    input  logic [18:0]         inv_vppn,
    output logic                inv_busy,
    output logic                inv_done,
    output logic                inv_err
);
    localparam int RSPW = 33 + IDXW;

    typedef enum logic [1:0] {IDLE, WALK, DONE} inv_state_t;

    // Entry body layout matches w_entry[87:0]; only the valid bits need a reset.
    logic [87:0]       ent_body [TLBNUM];
    logic [TLBNUM-1:0] ent_e;
    logic [IDXW-1:0]   fill_cnt;
    logic              wr_en;
    logic [IDXW-1:0]   wr_idx;

    inv_state_t        state, next_state;
    logic [IDXW-1:0]   ptr;
    logic [4:0]        op_q;
    logic [9:0]        asid_q;
    logic [18:0]       vppn_q;
    logic              bad_op;

    function automatic logic va_match(input logic [18:0] ent_vppn, input logic [5:0] ent_ps,
                                      input logic [18:0] key);
        if (ent_ps == 6'd12)
            return ent_vppn == key;
        return ent_vppn[18:9] == key[18:9];
    endfunction

    logic [18:0]     key_vppn  [2];
    logic            key_bit12 [2];
    logic [9:0]      key_asid  [2];
    logic [RSPW-1:0] lookup    [2];

    assign key_vppn[0]  = s0_vppn;
    assign key_vppn[1]  = s1_vppn;
    assign key_bit12[0] = s0_va_bit12;
    assign key_bit12[1] = s1_va_bit12;
    assign key_asid[0]  = s0_asid;
    assign key_asid[1]  = s1_asid;

    for (genvar p = 0; p < 2; p++) begin : g_search
        logic            found;
        logic [IDXW-1:0] hit_idx;
        logic [5:0]      hit_ps;
        logic            odd;
        logic [25:0]     hit_page;

        // Scanning from the top down leaves the lowest matching index in hit_idx.
        always_comb begin
            found   = 1'b0;
            hit_idx = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (ent_e[i] && (ent_body[i][52] || ent_body[i][62:53] == key_asid[p]) &&
                    va_match(ent_body[i][87:69], ent_body[i][68:63], key_vppn[p])) begin
                    found   = 1'b1;
                    hit_idx = IDXW'(i);
                end
            end
        end

        assign hit_ps   = ent_body[hit_idx][68:63];
        assign odd      = (hit_ps == 6'd12) ? key_bit12[p] : key_vppn[p][8];
        assign hit_page = odd ? ent_body[hit_idx][25:0] : ent_body[hit_idx][51:26];
        assign lookup[p] = found ? {1'b1, hit_idx, hit_page[25:6], hit_ps, hit_page[5:0]}
                                 : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0_rsp_valid <= 1'b0;
            s0_rsp       <= '0;
            s1_rsp_valid <= 1'b0;
            s1_rsp       <= '0;
            r_valid      <= 1'b0;
            r_entry      <= '0;
        end else begin
            s0_rsp_valid <= s0_req;
            s1_rsp_valid <= s1_req;
            r_valid      <= r_req;
            if (s0_req)
                s0_rsp <= lookup[0];
            if (s1_req)
                s1_rsp <= lookup[1];
            if (r_req)
                r_entry <= {ent_e[r_index], ent_body[r_index]};
        end
    end

    assign w_ready = ~inv_busy;
    assign wr_en   = we & w_ready;
    assign wr_idx  = w_fill ? fill_cnt : w_index;

    always_ff @(posedge clk) begin
        if (wr_en)
            ent_body[wr_idx] <= w_entry[87:0];
    end

    logic [5:0] walk_ps;
    logic       walk_g, walk_asid_eq, walk_va, walk_hit;

    assign walk_ps      = ent_body[ptr][68:63];
    assign walk_g       = ent_body[ptr][52];
    assign walk_asid_eq = ent_body[ptr][62:53] == asid_q;
    assign walk_va      = va_match(ent_body[ptr][87:69], walk_ps, vppn_q);

    always_comb begin
        walk_hit = 1'b0;
        case (op_q)
            5'd0, 5'd1: walk_hit = 1'b1;
            5'd2:       walk_hit = walk_g;
            5'd3:       walk_hit = ~walk_g;
            5'd4:       walk_hit = ~walk_g & walk_asid_eq;
            5'd5:       walk_hit = ~walk_g & walk_asid_eq & walk_va;
            5'd6:       walk_hit = (walk_g | walk_asid_eq) & walk_va;
            default:    walk_hit = 1'b0;
        endcase
    end

    // Writes and walk clears never collide: writes are refused while the walker is busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_e        <= '0;
            fill_cnt     <= '0;
            w_fill_index <= '0;
        end else begin
            fill_cnt <= fill_cnt + 1'b1;
            if (wr_en) begin
                ent_e[wr_idx] <= w_entry[88];
                w_fill_index  <= wr_idx;
            end
            if (state == WALK && walk_hit)
                ent_e[ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            ptr     <= '0;
            op_q    <= '0;
            asid_q  <= '0;
            vppn_q  <= '0;
            inv_err <= 1'b0;
        end else begin
            state   <= next_state;
            inv_err <= bad_op;
            ptr     <= (state == WALK) ? ptr + 1'b1 : '0;
            if (state == IDLE && inv_start) begin
                op_q   <= inv_op;
                asid_q <= inv_asid;
                vppn_q <= inv_vppn;
            end
        end
    end

    always_comb begin
        next_state = state;
        inv_busy   = 1'b0;
        inv_done   = 1'b0;
        bad_op     = 1'b0;
        case (state)
            IDLE: begin
                if (inv_start) begin
                    if (inv_op <= 5'd6)
                        next_state = WALK;
                    else
                        bad_op = 1'b1;
                end
            end
            WALK: begin
                inv_busy = 1'b1;
                if (ptr == IDXW'(TLBNUM - 1))
                    next_state = DONE;
            end
            DONE: begin
                inv_busy   = 1'b1;
                inv_done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed and randomized checks of tlb_unit against a behavioural
// TLB model kept as an array of entry records inside the bench.
module tb_tlb_unit;
    localparam int N    = 16;
    localparam int IDXW = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              s0_req = 1'b0, s1_req = 1'b0;
    logic [18:0]       s0_vppn = '0, s1_vppn = '0;
    logic              s0_va_bit12 = 1'b0, s1_va_bit12 = 1'b0;
    logic [9:0]        s0_asid = '0, s1_asid = '0;
    logic              s0_rsp_valid, s1_rsp_valid;
    logic [32+IDXW:0]  s0_rsp, s1_rsp;
    logic              we = 1'b0, w_fill = 1'b0;
    logic [IDXW-1:0]   w_index = '0;
    logic [88:0]       w_entry = '0;
    logic              w_ready;
    logic [IDXW-1:0]   w_fill_index;
    logic              r_req = 1'b0;
    logic [IDXW-1:0]   r_index = '0;
    logic              r_valid;
    logic [88:0]       r_entry;
    logic              inv_start = 1'b0;
    logic [4:0]        inv_op = '0;
    logic [9:0]        inv_asid = '0;
    logic [18:0]       inv_vppn = '0;
    logic              inv_busy, inv_done, inv_err;

    tlb_unit #(.TLBNUM(N), .IDXW(IDXW)) dut (
        .clk(clk), .resetn(resetn),
        .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_rsp_valid(s0_rsp_valid), .s0_rsp(s0_rsp),
        .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_rsp_valid(s1_rsp_valid), .s1_rsp(s1_rsp),
        .we(we), .w_fill(w_fill), .w_index(w_index), .w_entry(w_entry),
        .w_ready(w_ready), .w_fill_index(w_fill_index),
        .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_entry(r_entry),
        .inv_start(inv_start), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .inv_busy(inv_busy), .inv_done(inv_done), .inv_err(inv_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [25:0] pg0;
        logic [25:0] pg1;
    } ent_t;

    ent_t            model [N];
    logic [IDXW-1:0] m_cnt = '0;
    int              checks = 0;
    int              failures = 0;
    logic [18:0]     vpool [4] = '{19'h00010, 19'h00011, 19'h12345, 19'h12200};

    // The fill pointer is simply the number of clock edges since reset, modulo N.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_cnt <= '0;
        else         m_cnt <= m_cnt + 1'b1;
    end

    function automatic logic [88:0] pack_ent(input ent_t x);
        return {x.e, x.vppn, x.ps, x.asid, x.g, x.pg0, x.pg1};
    endfunction

    function automatic ent_t unpack_ent(input logic [88:0] w);
        ent_t x;
        x.e = w[88]; x.vppn = w[87:69]; x.ps = w[68:63]; x.asid = w[62:53];
        x.g = w[52]; x.pg0 = w[51:26]; x.pg1 = w[25:0];
        return x;
    endfunction

    function automatic logic page_ok(input ent_t x, input logic [18:0] vppn);
        if (x.ps == 6'd12) return x.vppn == vppn;
        return x.vppn[18:9] == vppn[18:9];
    endfunction

    function automatic logic [36:0] model_search(input logic [18:0] vppn, input logic bit12,
                                                 input logic [9:0] asid);
        ent_t        x;
        logic [25:0] pg;
        for (int i = 0; i < N; i++) begin
            x = model[i];
            if (x.e && (x.g || x.asid == asid) && page_ok(x, vppn)) begin
                pg = (((x.ps == 6'd12) ? bit12 : vppn[8]) == 1'b1) ? x.pg1 : x.pg0;
                return {1'b1, 4'(i), pg[25:6], x.ps, pg[5:0]};
            end
        end
        return '0;
    endfunction

    function automatic logic model_inv_hit(input int op, input logic [9:0] asid,
                                           input logic [18:0] vppn, input ent_t x);
        logic a = (x.asid == asid);
        logic v = page_ok(x, vppn);
        case (op)
            0, 1: return 1'b1;
            2:    return x.g;
            3:    return !x.g;
            4:    return !x.g && a;
            5:    return !x.g && a && v;
            6:    return (x.g || a) && v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ent_t rand_ent();
        ent_t x;
        x.e    = ($urandom_range(0, 4) != 0);
        x.vppn = vpool[$urandom_range(0, 3)];
        x.ps   = ($urandom_range(0, 1) == 1) ? 6'd12 : 6'd21;
        x.asid = ($urandom_range(0, 1) == 1) ? 10'd5 : 10'd6;
        x.g    = ($urandom_range(0, 3) == 0);
        x.pg0  = 26'($urandom);
        x.pg1  = 26'($urandom);
        return x;
    endfunction

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input int idx, input ent_t x);
        we = 1'b1; w_fill = 1'b0; w_index = 4'(idx); w_entry = pack_ent(x);
        applyStimulus();
        we = 1'b0;
        model[idx] = x;
    endtask

    task automatic search0(input logic [18:0] vppn, input logic bit12, input logic [9:0] asid,
                           input string tag);
        logic [36:0] exp;
        exp = model_search(vppn, bit12, asid);
        s0_req = 1'b1; s0_vppn = vppn; s0_va_bit12 = bit12; s0_asid = asid;
        applyStimulus();
        s0_req = 1'b0;
        checkOutput({tag, "_valid"}, 128'(s0_rsp_valid), 128'(1'b1));
        checkOutput(tag, 128'(s0_rsp), 128'(exp));
    endtask

    task automatic read_check(input int idx, input logic full, input string tag);
        logic [88:0] exp;
        exp = pack_ent(model[idx]);
        r_req = 1'b1; r_index = 4'(idx);
        applyStimulus();
        r_req = 1'b0;
        checkOutput({tag, "_rvalid"}, 128'(r_valid), 128'(1'b1));
        if (full) checkOutput(tag, 128'(r_entry), 128'(exp));
        else      checkOutput(tag, 128'(r_entry[88]), 128'(exp[88]));
    endtask

    initial begin
        ent_t        x;
        logic [36:0] e0, e1;
        logic [88:0] er;
        logic [3:0]  widx;
        logic        q0, q1, qr, qw;
        int          busy_cycles;
        logic        seen_done;

        #12;
        checkOutput("reset_search", 128'({s0_rsp_valid, s0_rsp, s1_rsp_valid, s1_rsp}), 128'(0));
        checkOutput("reset_status",
                    128'({w_ready, inv_busy, inv_done, inv_err, r_valid, w_fill_index}),
                    128'(9'h100));
        checkOutput("reset_rentry", 128'(r_entry), 128'(0));
        resetn = 1'b1;

        for (int i = 0; i < N; i++) begin
            x = '{e: 1'b0, vppn: 19'(i), ps: 6'd12, asid: 10'd0, g: 1'b0,
                  pg0: 26'($urandom), pg1: 26'($urandom)};
            write_entry(i, x);
        end
        read_check(7, 1'b1, "init_read7");

        // Basic hit, both ports on the same entry in the same cycle.
        x = '{e: 1'b1, vppn: 19'h00010, ps: 6'd12, asid: 10'd5, g: 1'b0,
              pg0: {20'h00111, 6'd0}, pg1: {20'h00222, 6'd0}};
        write_entry(3, x);
        e0 = model_search(19'h00010, 1'b1, 10'd5);
        e1 = model_search(19'h00010, 1'b0, 10'd5);
        s0_req = 1'b1; s0_vppn = 19'h00010; s0_va_bit12 = 1'b1; s0_asid = 10'd5;
        s1_req = 1'b1; s1_vppn = 19'h00010; s1_va_bit12 = 1'b0; s1_asid = 10'd5;
        applyStimulus();
        s0_req = 1'b0; s1_req = 1'b0;
        checkOutput("hit_s0_model", 128'(s0_rsp), 128'(e0));
        checkOutput("hit_s1_model", 128'(s1_rsp), 128'(e1));
        checkOutput("hit_s0_const", 128'(s0_rsp), 128'({1'b1, 4'd3, 20'h00222, 6'd12, 6'd0}));
        checkOutput("hit_s1_const", 128'(s1_rsp), 128'({1'b1, 4'd3, 20'h00111, 6'd12, 6'd0}));
        applyStimulus();
        checkOutput("idle_valid", 128'({s0_rsp_valid, s1_rsp_valid}), 128'(0));
        checkOutput("rsp_hold", 128'(s0_rsp), 128'({1'b1, 4'd3, 20'h00222, 6'd12, 6'd0}));

        search0(19'h00010, 1'b1, 10'd6, "asid_miss");
        checkOutput("asid_miss_const", 128'(s0_rsp), 128'(0));
        x.g = 1'b1;
        write_entry(3, x);
        search0(19'h00010, 1'b1, 10'd6, "global_hit");
        checkOutput("global_hit_const", 128'(s0_rsp),
                    128'({1'b1, 4'd3, 20'h00222, 6'd12, 6'd0}));

        // Priority between two identical entries, then a 2MB page.
        x = '{e: 1'b1, vppn: 19'h00400, ps: 6'd12, asid: 10'd7, g: 1'b0,
              pg0: {20'h00900, 6'd1}, pg1: {20'h00901, 6'd2}};
        write_entry(9, x);
        x.pg0 = {20'h00200, 6'd3};
        write_entry(2, x);
        search0(19'h00400, 1'b0, 10'd7, "prio");
        checkOutput("prio_const", 128'(s0_rsp), 128'({1'b1, 4'd2, 20'h00200, 6'd12, 6'd3}));
        x = '{e: 1'b1, vppn: 19'h12345, ps: 6'd21, asid: 10'd7, g: 1'b0,
              pg0: {20'hAAAAA, 6'd0}, pg1: {20'hBBBBB, 6'd0}};
        write_entry(5, x);
        search0(19'h12200, 1'b1, 10'd7, "big_even");
        checkOutput("big_even_const", 128'(s0_rsp), 128'({1'b1, 4'd5, 20'hAAAAA, 6'd21, 6'd0}));
        search0(19'h12300, 1'b0, 10'd7, "big_odd");
        checkOutput("big_odd_const", 128'(s0_rsp), 128'({1'b1, 4'd5, 20'hBBBBB, 6'd21, 6'd0}));

        // Randomized traffic on every port at once.
        for (int c = 0; c < 300; c++) begin
            we = ($urandom_range(0, 1) == 1); w_fill = ($urandom_range(0, 1) == 1);
            w_index = 4'($urandom); w_entry = pack_ent(rand_ent());
            s0_req = ($urandom_range(0, 3) != 0); s0_vppn = vpool[$urandom_range(0, 3)];
            s0_va_bit12 = 1'($urandom); s0_asid = ($urandom_range(0, 1) == 1) ? 10'd5 : 10'd6;
            s1_req = ($urandom_range(0, 3) != 0); s1_vppn = vpool[$urandom_range(0, 3)];
            s1_va_bit12 = 1'($urandom); s1_asid = ($urandom_range(0, 1) == 1) ? 10'd5 : 10'd6;
            r_req = ($urandom_range(0, 1) == 1); r_index = 4'($urandom);
            e0 = model_search(s0_vppn, s0_va_bit12, s0_asid);
            e1 = model_search(s1_vppn, s1_va_bit12, s1_asid);
            er = pack_ent(model[r_index]);
            widx = w_fill ? m_cnt : w_index;
            q0 = s0_req; q1 = s1_req; qr = r_req; qw = we;
            applyStimulus();
            checkOutput("rnd_valid", 128'({s0_rsp_valid, s1_rsp_valid, r_valid}), 128'({q0, q1, qr}));
            if (q0) checkOutput("rnd_s0", 128'(s0_rsp), 128'(e0));
            if (q1) checkOutput("rnd_s1", 128'(s1_rsp), 128'(e1));
            if (qr) checkOutput("rnd_read", 128'(r_entry), 128'(er));
            if (qw) begin
                checkOutput("rnd_fill_index", 128'(w_fill_index), 128'(widx));
                model[widx] = unpack_ent(w_entry);
            end
        end
        we = 1'b0; s0_req = 1'b0; s1_req = 1'b0; r_req = 1'b0;

        // Invalidate by ASID, with searches and refused writes during the walk.
        write_entry(1, '{e: 1'b1, vppn: 19'h00011, ps: 6'd12, asid: 10'd5, g: 1'b0,
                         pg0: 26'h1, pg1: 26'h2});
        write_entry(4, '{e: 1'b1, vppn: 19'h00011, ps: 6'd12, asid: 10'd5, g: 1'b1,
                         pg0: 26'h3, pg1: 26'h4});
        write_entry(6, '{e: 1'b1, vppn: 19'h00011, ps: 6'd12, asid: 10'd6, g: 1'b0,
                         pg0: 26'h5, pg1: 26'h6});
        inv_op = 5'd4; inv_asid = 10'd5; inv_vppn = vpool[$urandom_range(0, 3)]; inv_start = 1'b1;
        applyStimulus();
        inv_start = 1'b0;
        checkOutput("walk_start", 128'({inv_busy, inv_done, w_ready}), 128'(3'b100));
        busy_cycles = inv_busy ? 1 : 0;
        for (int c = 0; c <= N; c++) begin
            we = 1'b1; w_fill = 1'b0; w_index = 4'($urandom);
            x = rand_ent(); x.e = 1'b1; w_entry = pack_ent(x);
            s0_req = 1'b1; s0_vppn = vpool[$urandom_range(0, 3)]; s0_va_bit12 = 1'($urandom);
            s0_asid = ($urandom_range(0, 1) == 1) ? 10'd5 : 10'd6;
            e0 = model_search(s0_vppn, s0_va_bit12, s0_asid);
            applyStimulus();
            checkOutput("walk_search", 128'(s0_rsp), 128'(e0));
            if (c < N && model_inv_hit(4, 10'd5, inv_vppn, model[c])) model[c].e = 1'b0;
            if (inv_busy) busy_cycles++;
            checkOutput("walk_done", 128'(inv_done), 128'(c == N - 1));
        end
        we = 1'b0; s0_req = 1'b0;
        checkOutput("walk_busy_cycles", 128'(busy_cycles), 128'(17));
        checkOutput("walk_end_busy", 128'(inv_busy), 128'(0));
        for (int i = 0; i < N; i++) read_check(i, 1'b1, "walk_read");

        // Illegal opcode.
        inv_op = 5'd7; inv_start = 1'b1;
        applyStimulus();
        inv_start = 1'b0;
        checkOutput("err_pulse", 128'({inv_err, inv_busy}), 128'(2'b10));
        applyStimulus();
        checkOutput("err_clear", 128'({inv_err, inv_busy}), 128'(0));
        read_check(6, 1'b1, "err_read6");
        read_check(4, 1'b1, "err_read4");

        // Reset in the middle of a walk.
        for (int i = 0; i < 4; i++) begin
            x = rand_ent(); x.e = 1'b1;
            write_entry(i + 8, x);
        end
        inv_op = 5'd0; inv_start = 1'b1;
        applyStimulus();
        inv_start = 1'b0;
        for (int c = 0; c < 5; c++) applyStimulus();
        resetn = 1'b0;
        #2;
        checkOutput("abort_reset",
                    128'({inv_busy, inv_done, inv_err, s0_rsp_valid, r_valid, w_fill_index}),
                    128'(0));
        resetn = 1'b1;
        for (int i = 0; i < N; i++) model[i].e = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus();
            if (inv_done) seen_done = 1'b1;
        end
        checkOutput("abort_no_done", 128'(seen_done), 128'(0));
        for (int i = 0; i < N; i++) read_check(i, 1'b0, "abort_e");
        search0(19'h00011, 1'b0, 10'd6, "abort_search");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
